// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit:
//   - Size input encodings (byte/half/word, signed and unsigned variants)
//   - FSM state enum (IDLE, REQ, DONE)
//   - access width enum and decoded-size struct
//   - byte-enable base patterns for byte/half/word lanes
//   - decode_size(): maps the raw 3-bit Size code to width + sign-extend flag
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;  // signed byte
  localparam logic [2:0] SIZE_H  = 3'b001;  // signed half
  localparam logic [2:0] SIZE_W  = 3'b010;  // word
  localparam logic [2:0] SIZE_BU = 3'b100;  // unsigned byte
  localparam logic [2:0] SIZE_HU = 3'b101;  // unsigned half

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    WID_BYTE = 2'd0,
    WID_HALF = 2'd1,
    WID_WORD = 2'd2
  } lsu_width_e;

  typedef struct packed {
    lsu_width_e width;
    logic       sext;   // sign-extend narrow loads
  } lsu_size_t;

  // Unlisted codes fall back to a plain word access.
  function automatic lsu_size_t decode_size(input logic [2:0] code);
    lsu_size_t d;
    d.width = WID_WORD;
    d.sext  = 1'b0;
    case (code)
      SIZE_B:  begin d.width = WID_BYTE; d.sext = 1'b1; end
      SIZE_H:  begin d.width = WID_HALF; d.sext = 1'b1; end
      SIZE_W:  d.width = WID_WORD;
      SIZE_BU: d.width = WID_BYTE;
      SIZE_HU: d.width = WID_HALF;
      default: d.width = WID_WORD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Purely combinational load extraction: selects the addressed byte or half
// lane of the returned bus word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_i  [31:0]  word returned by memory
//   size_i           decoded access size (width + sign-extend flag)
//   offset_i [1:0]   byte offset inside the word (already aligned for halves)
//   data_o   [31:0]  extended load result
// ----------------------------------------------------------------------------
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  lsu_size_t   size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
    half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o    = rdata_i;
    case (size_i.width)
      WID_BYTE: data_o = {{24{size_i.sext & byte_lane[7]}}, byte_lane};
      WID_HALF: data_o = {{16{size_i.sext & half_lane[15]}}, half_lane};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// M-stage load/store unit with a single outstanding bus transaction.
// FSM: IDLE -> REQ (bus_req high until bus_ack) -> DONE -> IDLE.
// Stall is raised combinationally in the launching IDLE cycle and held
// through REQ; DONE releases the pipeline and always returns to IDLE, so the
// same instruction never relaunches.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   mem_en, MemRW         access present / 1=store 0=load
//   Size[2:0]             access size code (see load_store_unit_pkg)
//   addr[31:0], wdata     effective address and right-justified store data
//   stall                 holds F/D/X/M pipeline registers
//   load_data[31:0]       extended load result, held until the next load
//   misaligned            one-cycle trap pulse (trap build only, else 0)
//   bus_req, bus_we       request strobe and write enable
//   bus_addr, bus_be      word address and byte enables
//   bus_wdata             lane-replicated store data
//   bus_ack, bus_rdata    single-cycle completion and read word
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word accesses trap and never reach the bus
//   undefined -> low address bits are forced to natural alignment
// ----------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        MemRW,
  input  logic [2:0]  Size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  state_q, state_d;

  lsu_size_t   req_size;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        access_legal;
  logic        launch;
  logic        capture;

  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  lsu_size_t   size_q;
  logic [1:0]  off_q;
  logic [31:0] load_data_q;
  logic [31:0] aligned_data;

  assign req_size = decode_size(Size);

  // Request formatting: lane offset (forced to natural alignment), byte
  // enables and replicated store data, all derived from the live M-stage
  // inputs and captured on launch.
  always_comb begin : req_format
    req_off   = addr[1:0];
    req_be    = BE_WORD;
    req_wdata = wdata;
    case (req_size.width)
      WID_BYTE: begin
        req_be    = BE_BYTE << req_off;
        req_wdata = {4{wdata[7:0]}};
      end
      WID_HALF: begin
        req_off[0] = 1'b0;
        req_be     = BE_HALF << req_off;
        req_wdata  = {2{wdata[15:0]}};
      end
      default: begin
        req_off = 2'b00;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic access_misaligned;
  logic trap;
  logic misaligned_q;

  assign access_misaligned =
      ((req_size.width == WID_HALF) && addr[0]) ||
      ((req_size.width == WID_WORD) && (addr[1:0] != 2'b00));
  assign access_legal = !access_misaligned;
  assign trap = (state_q == ST_IDLE) && mem_en && access_misaligned && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= trap;
  end

  assign misaligned = misaligned_q;
`else
  assign access_legal = 1'b1;
  assign misaligned   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_en && access_legal) state_d = ST_REQ;
      ST_REQ:  if (bus_ack)                state_d = ST_DONE;
      ST_DONE:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Reset masks the launch so stall is low while held in reset.
  // --------------------------------------------------------------------------
  always_comb begin : fsm_out
    launch  = 1'b0;
    stall   = 1'b0;
    bus_req = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        launch = mem_en && access_legal && !reset;
        stall  = launch;
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        capture = bus_ack;   // ack outside REQ is never looked at
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      load_data_q <= '0;
    end else begin
      // Captured once at launch so the bus fields stay stable through REQ.
      if (launch) begin
        we_q    <= MemRW;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= req_be;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        off_q   <= req_off;
      end
      // Stores complete without touching the load result.
      if (capture && !we_q) load_data_q <= aligned_data;
    end
  end

  lsu_load_align u_load_align (
    .rdata_i  (bus_rdata),
    .size_i   (size_q),
    .offset_i (off_q),
    .data_o   (aligned_data)
  );

  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Directed scenarios plus randomized loads/stores against a byte-level
// reference model. Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        MemRW;
  logic [2:0]  Size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;
  int txn_cnt  = 0;
  int mis_cnt  = 0;
  logic [31:0] exp_ld;

  logic [31:0] bus_mem [16];  // memory as seen through the DUT's bus writes
  logic [31:0] ref_mem [16];  // memory as the instruction semantics define it

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    logic        first_req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    bit          stable;
    bit          finished;
    logic [31:0] ld;
    logic        done_stall;
    logic        done_req;
  } obs_t;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mem_en     (mem_en),
    .MemRW      (MemRW),
    .Size       (Size),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_req && bus_ack) txn_cnt++;
    if (misaligned)         mis_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model (byte-addressed semantics)
  // --------------------------------------------------------------------------
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [2:0] sz);
    return a - (a % nbytes(sz));
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] ea = m_addr(a, sz);
    return 4'(((1 << nbytes(sz)) - 1) << (ea % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [2:0] sz);
    logic [31:0] b = {24'h0, wd[7:0]};
    logic [31:0] h = {16'h0, wd[15:0]};
    case (nbytes(sz))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] sz);
    int          n  = nbytes(sz);
    logic [31:0] ea = m_addr(a, sz);
    logic [31:0] mask;
    logic [31:0] v;
    if (n == 4) return word;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v    = (word >> (8 * (ea % 4))) & mask;
    if (!sz[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Drive one access and act as the memory; acks on the ack_on-th REQ cycle.
  // Returns with the DUT in DONE (mem_en still high, as the pipeline would).
  // --------------------------------------------------------------------------
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_on,
                        output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    @(negedge clk);
    mem_en = 1'b1; MemRW = we; Size = sz; addr = a; wdata = wd;
    bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    o.first_req = bus_req;
    if (stall) o.stall_cnt++;
    for (int k = 0; k < 20 && !o.finished; k++) begin
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      #1;
      if (bus_req) begin
        o.req_cnt++;
        if (o.req_cnt == 1) begin
          o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata; o.we = bus_we;
        end else if (bus_addr !== o.addr || bus_be !== o.be ||
                     bus_wdata !== o.wdata || bus_we !== o.we) begin
          o.stable = 1'b0;
        end
        if (o.req_cnt == ack_on) begin bus_ack = 1'b1; bus_rdata = rd; end
      end else if (o.req_cnt > 0 && o.req_cnt >= ack_on) begin
        o.finished = 1'b1; o.ld = load_data; o.done_stall = stall; o.done_req = bus_req;
      end
      if (stall) o.stall_cnt++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; mem_en = 1'b0; MemRW = 1'b0; Size = 3'b010;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
    checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL rst_load_data got=%h exp=0", load_data); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%b exp=0", misaligned); end
    checks++;
    if ({bus_we, bus_addr, bus_be, bus_wdata} !== 69'h0) begin
      failures++;
      $display("FAIL rst_bus_fields we=%b addr=%h be=%b wdata=%h exp=all zero",
               bus_we, bus_addr, bus_be, bus_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_ld = 32'h0;
  endtask

  task automatic test_load_word();
    obs_t o;
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, o);
    checks++; if (!o.finished) begin failures++; $display("FAIL lw_timeout got=no DONE exp=DONE"); end
    checks++; if (o.stall_cnt !== 4) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=4", o.stall_cnt); end
    checks++; if (o.ld !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_load_data got=%h exp=deadbeef", o.ld); end
    checks++; if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.we !== 1'b0) begin
      failures++; $display("FAIL lw_bus got addr=%h be=%b we=%b exp 00000100/1111/0", o.addr, o.be, o.we); end
    checks++; if (!o.stable) begin failures++; $display("FAIL lw_stable got=changed exp=stable"); end
    checks++; if (o.done_stall !== 1'b0 || o.done_req !== 1'b0) begin
      failures++; $display("FAIL lw_done got stall=%b req=%b exp 0/0", o.done_stall, o.done_req); end
    exp_ld = 32'hDEAD_BEEF;
    // DONE must fall back to IDLE without relaunching the held instruction.
    @(negedge clk); mem_en = 1'b0; #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL lw_no_relaunch got req=%b stall=%b exp 0/0", bus_req, stall); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 1, o);
    checks++; if (o.be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", o.be); end
    checks++; if (o.ld !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", o.ld); end
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 2, o);
    checks++; if (o.ld !== 32'h0000_0080) begin failures++; $display("FAIL lbu_unsigned got=%h exp=00000080", o.ld); end
    exp_ld = 32'h0000_0080;
    @(negedge clk); mem_en = 1'b0;
  endtask

  task automatic test_store_half();
    obs_t o;
    access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 2, o);
    checks++; if (o.we !== 1'b1) begin failures++; $display("FAIL sh_we got=%b exp=1", o.we); end
    checks++; if (o.be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", o.be); end
    checks++; if (o.wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o.wdata); end
    checks++; if (o.addr !== 32'h200) begin failures++; $display("FAIL sh_addr got=%h exp=00000200", o.addr); end
    checks++; if (o.ld !== exp_ld) begin failures++; $display("FAIL sh_load_data_kept got=%h exp=%h", o.ld, exp_ld); end
    @(negedge clk); mem_en = 1'b0;
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    int t0 = txn_cnt;
    @(negedge clk);
    mem_en = 1'b1; MemRW = 1'b0; Size = 3'b010; addr = 32'h101; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%b exp=0", stall); end
    @(negedge clk); mem_en = 1'b0; #1;
    checks++; if (misaligned !== 1'b1 || bus_req !== 1'b0) begin
      failures++; $display("FAIL mis_pulse got mis=%b req=%b exp 1/0", misaligned, bus_req); end
    @(negedge clk); #1;
    checks++; if (misaligned !== 1'b0 || bus_req !== 1'b0 || txn_cnt != t0) begin
      failures++; $display("FAIL mis_end got mis=%b req=%b txns=%0d exp 0/0/%0d", misaligned, bus_req, txn_cnt, t0); end
`else
    obs_t o;
    int   m0 = mis_cnt;
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0BAD_F00D, 1, o);
    checks++; if (o.addr !== 32'h100 || o.be !== 4'b1111) begin
      failures++; $display("FAIL mis_forced got addr=%h be=%b exp 00000100/1111", o.addr, o.be); end
    checks++; if (o.ld !== 32'h0BAD_F00D) begin failures++; $display("FAIL mis_load got=%h exp=0badf00d", o.ld); end
    checks++; if (mis_cnt != m0) begin failures++; $display("FAIL mis_tied_low got=%0d pulses exp=0", mis_cnt - m0); end
    exp_ld = 32'h0BAD_F00D;
    @(negedge clk); mem_en = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_req();
    int t0;
    @(negedge clk);
    mem_en = 1'b1; MemRW = 1'b0; Size = 3'b010; addr = 32'h40; bus_ack = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rmid_in_req got=%b exp=1", bus_req); end
    #1 reset = 1'b1; #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rmid_drop got req=%b stall=%b exp 0/0", bus_req, stall); end
    mem_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    exp_ld = 32'h0;
    t0 = txn_cnt;
    for (int k = 0; k < 3; k++) begin
      bus_ack = 1'b1; bus_rdata = $urandom;
      @(negedge clk); #1;
      checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin
        failures++; $display("FAIL rmid_stray_ack%0d got req=%b stall=%b exp 0/0", k, bus_req, stall); end
    end
    bus_ack = 1'b0;
    checks++; if (load_data !== 32'h0 || txn_cnt != t0) begin
      failures++; $display("FAIL rmid_no_effect got ld=%h txns=%0d exp 0/%0d", load_data, txn_cnt, t0); end
  endtask

  task automatic test_back_to_back();
    obs_t os, ol;
    int   t0 = txn_cnt;
    access(1'b1, 3'b010, 32'h10, 32'hCAFE_0123, 32'h0, 1, os);
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFE_0123, 2, ol);
    checks++; if (!os.finished || !ol.finished) begin
      failures++; $display("FAIL b2b_timeout got st=%b ld=%b exp 1/1", os.finished, ol.finished); end
    checks++; if (ol.first_req !== 1'b0 || ol.stall_cnt !== 3 || ol.req_cnt !== 2) begin
      failures++; $display("FAIL b2b_sequence got first_req=%b stall=%0d req=%0d exp 0/3/2",
                           ol.first_req, ol.stall_cnt, ol.req_cnt); end
    checks++; if (txn_cnt - t0 != 2) begin failures++; $display("FAIL b2b_txns got=%0d exp=2", txn_cnt - t0); end
    checks++; if (ol.ld !== 32'hCAFE_0123) begin failures++; $display("FAIL b2b_load got=%h exp=cafe0123", ol.ld); end
    exp_ld = 32'hCAFE_0123;
    @(negedge clk); mem_en = 1'b0;
  endtask

  task automatic test_random();
    obs_t        o;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a, wd, rd, word, ea;
    int          ack_on, idx;
    for (int i = 0; i < 16; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    for (int i = 0; i < 60; i++) begin
      we     = 1'($urandom_range(0, 1));
      sz     = 3'($urandom_range(0, 7));
      a      = 32'($urandom_range(0, 63));
      wd     = $urandom;
      ack_on = $urandom_range(1, 3);
`ifdef LSU_MISALIGN_TRAP_EN
      a = m_addr(a, sz);
`endif
      idx = int'(a[5:2]);
      rd  = bus_mem[idx];
      access(we, sz, a, wd, rd, ack_on, o);
      checks++; if (!o.finished) begin failures++; $display("FAIL rnd%0d_timeout got=no DONE exp=DONE", i); end
      checks++; if (o.stall_cnt !== ack_on + 1 || o.req_cnt !== ack_on || !o.stable) begin
        failures++; $display("FAIL rnd%0d_timing got stall=%0d req=%0d stable=%b exp %0d/%0d/1",
                             i, o.stall_cnt, o.req_cnt, o.stable, ack_on + 1, ack_on); end
      checks++; if (o.addr !== {a[31:2], 2'b00} || o.be !== m_be(a, sz) || o.we !== we) begin
        failures++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b exp %h/%b/%b",
                             i, o.addr, o.be, o.we, {a[31:2], 2'b00}, m_be(a, sz), we); end
      if (we) begin
        checks++; if (o.wdata !== m_wdata(wd, sz)) begin
          failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o.wdata, m_wdata(wd, sz)); end
        // Environment memory follows the DUT's bus write.
        for (int b = 0; b < 4; b++)
          if (o.be[b]) bus_mem[idx][8*b +: 8] = o.wdata[8*b +: 8];
        // Reference memory follows the instruction's byte semantics.
        ea   = m_addr(a, sz);
        word = ref_mem[idx];
        for (int b = 0; b < nbytes(sz); b++)
          word[8*(int'(ea % 4) + b) +: 8] = wd[8*b +: 8];
        ref_mem[idx] = word;
      end else begin
        exp_ld = m_load(ref_mem[idx], a, sz);
      end
      checks++; if (o.ld !== exp_ld) begin
        failures++; $display("FAIL rnd%0d_load_data got=%h exp=%h we=%b sz=%b a=%h", i, o.ld, exp_ld, we, sz, a); end
    end
    @(negedge clk); mem_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_reset_mid_req();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  sole clock, rising-edge.
REQ-002 reset  input  1  asynchronous, active-high; all state cleared immediately on assertion.
REQ-003 mem_en  input  1  M-stage instruction is a load or a store.
REQ-004 MemRW  input  1  1=store, 0=load; meaningful only with mem_en.
REQ-005 Size  input  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; other codes are treated as word.
REQ-006 addr  input  32  ALU effective address.
REQ-007 wdata  input  32  store data, rs2, right-justified.
REQ-008 stall  output  1  holds F/D/X/M pipeline registers while high.
REQ-009 load_data  output  32  aligned, extended load result for WB.
REQ-010 misaligned  output  1  one-cycle trap pulse.
REQ-011 bus_req, bus_we  output  1 each  memory request strobe and write enable.
REQ-012 bus_addr  output  32  word address, bits[1:0]=00.
REQ-013 bus_be  output  4  byte enables.
REQ-014 bus_wdata  output  32  lane-replicated store data.
REQ-015 bus_ack  input  1  memory completion, single cycle.
REQ-016 bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-018 In IDLE with mem_en=1 and a legal access, stall SHALL go high combinationally in the same cycle, the request SHALL be registered, and the FSM SHALL enter REQ.
REQ-019 In REQ, bus_req=1, and bus_we/addr/be/wdata SHALL remain stable until bus_ack; stall SHALL stay high.
REQ-020 bus_ack SHALL be sampled only in REQ; an ack in any other state SHALL be ignored.
REQ-021 On bus_ack in REQ, the extended load data SHALL be registered into load_data and the FSM SHALL enter DONE; minimum latency from mem_en to DONE is 2 cycles.
REQ-022 In DONE, stall=0 and bus_req=0, and the FSM SHALL return to IDLE unconditionally, so the same instruction cannot relaunch.
REQ-023 Byte enables: byte 0001<<addr[1:0]; half 0011<<(addr[1]*2); word 1111.
REQ-024 bus_wdata: byte → wdata[7:0] replicated ×4; half → wdata[15:0] replicated ×2; word → wdata unchanged.
REQ-025 Load extract: byte → the lane selected by addr[1:0], half → the lane selected by addr[1]; sign-extended for Size 000/001, zero-extended for Size 100/101.
REQ-026 load_data SHALL hold its value until the next load completes; a store SHALL NOT alter load_data.
REQ-027 Reset in any state SHALL go to IDLE with bus_req=0 and drop any in-flight transaction without waiting for bus_ack.

Reset
REQ-028 The reset values SHALL be: state=IDLE, stall=0, load_data=0, misaligned=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0000, bus_wdata=0.

Configuration
REQ-029 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]≠00 SHALL pulse misaligned for 1 cycle from IDLE, issue no bus request, keep stall low, and stay in IDLE.
REQ-030 Without LSU_MISALIGN_TRAP_EN, addr low bits SHALL be forced to alignment (half: bit0=0; word: bits[1:0]=0), the access SHALL proceed normally, and misaligned SHALL be tied to 0.

Structure
REQ-031 A shared package SHALL hold the Size encodings, the FSM state enum, and the byte-enable constants.
REQ-032 The load extract/extend logic SHALL be one combinational sub-module named lsu_load_align.

Verification
REQ-033 Load word: addr=0x100, bus_ack on the 3rd REQ cycle, bus_rdata=0xDEADBEEF → stall high for 4 cycles, load_data=0xDEADBEEF in DONE.
REQ-034 Load byte signed: addr=0x103, bus_rdata=0x80FFFFFF → bus_be=1000, load_data=0xFFFFFF80; same access with Size=100 → load_data=0x00000080.
REQ-035 Store half: addr=0x202, wdata=0x1234ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
REQ-036 Reset asserted mid-REQ → bus_req=0 immediately, state=IDLE, and a later stray bus_ack has no effect.
REQ-037 Word access at addr=0x101 → with LSU_MISALIGN_TRAP_EN: misaligned=1 for 1 cycle and no bus_req; without it: bus_addr=0x100, bus_be=1111.
REQ-038 Back-to-back store then load → the store's DONE is followed by IDLE, then the load's REQ, with one bus transaction per instruction.
